// File: rtl/mc_seq_ctrl_if.sv
// Sequencer-to-datapath bundle: decoded class and status in, strobes and
// mux selects out. The sequencer is the master side.
interface mc_seq_ctrl_if;
    logic [3:0] op_class;
    logic       br_taken;
    logic       md_busy;
    logic       int_req;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic       dmem_we;
    logic       md_start;
    logic       exc_pulse;
    logic       md_err;
    logic [2:0] pc_sel;
    logic [2:0] rd_sel;
    logic [2:0] state;

    modport master (
        input  op_class, br_taken, md_busy, int_req,
        output ir_we, pc_we, rf_we, dmem_we, md_start, exc_pulse, md_err,
               pc_sel, rd_sel, state
    );

    modport slave (
        output op_class, br_taken, md_busy, int_req,
        input  ir_we, pc_we, rf_we, dmem_we, md_start, exc_pulse, md_err,
               pc_sel, rd_sel, state
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle instruction sequencer: IF/ID/EX/MEM/WAIT_MD/WB with
// mul/div stall, timeout, and trap/interrupt diversion in writeback.
module mc_seq_ctrl #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mc_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IF      = 3'd0,
        S_ID      = 3'd1,
        S_EX      = 3'd2,
        S_MEM     = 3'd3,
        S_WAIT_MD = 3'd4,
        S_WB      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_ALU    = 4'd0,
        C_LOAD   = 4'd1,
        C_STORE  = 4'd2,
        C_BRANCH = 4'd3,
        C_J      = 4'd4,
        C_JAL    = 4'd5,
        C_JR     = 4'd6,
        C_JALR   = 4'd7,
        C_MFC0   = 4'd8,
        C_ERET   = 4'd9,
        C_MFLO   = 4'd10,
        C_MFHI   = 4'd11,
        C_MUL    = 4'd12,
        C_CLZ    = 4'd13,
        C_MDOP   = 4'd14,
        C_TRAP   = 4'd15
    } cls_e;

    localparam int CW = $clog2(MD_TIMEOUT) + 1;

    state_e        state_q, next_state;
    cls_e          cls_q;
    logic          br_q;
    logic          md_to_q;
    logic [CW-1:0] md_cnt;
    logic          md_timeout;
    logic          exc;

    assign md_timeout = (md_cnt == CW'(MD_TIMEOUT - 1));
    assign bus.state  = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            cls_q   <= C_ALU;
            br_q    <= 1'b0;
            md_to_q <= 1'b0;
            md_cnt  <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == S_ID)
                cls_q <= cls_e'(bus.op_class);
            if (state_q == S_EX) begin
                br_q    <= bus.br_taken;
                md_cnt  <= '0;
                md_to_q <= 1'b0;
            end
            // A timeout is only an error if the unit was still busy on the last look
            if (state_q == S_WAIT_MD) begin
                md_cnt  <= md_cnt + 1'b1;
                md_to_q <= bus.md_busy && md_timeout;
            end
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IF:      next_state = S_ID;
            S_ID:      next_state = S_EX;
            S_EX: begin
                if (cls_q == C_LOAD || cls_q == C_STORE) next_state = S_MEM;
                else if (cls_q == C_MDOP)                next_state = S_WAIT_MD;
                else                                     next_state = S_WB;
            end
            S_MEM:     next_state = S_WB;
            S_WAIT_MD: if (!bus.md_busy || md_timeout) next_state = S_WB;
            S_WB:      next_state = S_IF;
            default:   next_state = S_IF;
        endcase
    end

    assign exc = (cls_q == C_TRAP) || (bus.int_req && cls_q != C_ERET);

    // Outputs are forced idle during reset so an aborted instruction never strobes
    always_comb begin
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.rf_we     = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.md_start  = 1'b0;
        bus.exc_pulse = 1'b0;
        bus.md_err    = 1'b0;
        bus.pc_sel    = 3'b000;
        bus.rd_sel    = 3'b000;
        if (!rst) begin
            case (state_q)
                S_IF:  bus.ir_we    = 1'b1;
                S_EX:  bus.md_start = (cls_q == C_MDOP);
                S_MEM: bus.dmem_we  = (cls_q == C_STORE);
                S_WB: begin
                    bus.pc_we  = 1'b1;
                    bus.md_err = md_to_q;
                    case (cls_q)
                        C_ALU, C_LOAD, C_JAL, C_JALR, C_MFC0,
                        C_MFLO, C_MFHI, C_MUL, C_CLZ: bus.rf_we = 1'b1;
                        default:                      bus.rf_we = 1'b0;
                    endcase
                    case (cls_q)
                        C_LOAD:        bus.rd_sel = 3'b001;
                        C_JAL, C_JALR: bus.rd_sel = 3'b010;
                        C_MFC0:        bus.rd_sel = 3'b011;
                        C_MFLO:        bus.rd_sel = 3'b100;
                        C_MFHI:        bus.rd_sel = 3'b101;
                        C_MUL:         bus.rd_sel = 3'b110;
                        C_CLZ:         bus.rd_sel = 3'b111;
                        default:       bus.rd_sel = 3'b000;
                    endcase
                    case (cls_q)
                        C_BRANCH:  bus.pc_sel = br_q ? 3'b011 : 3'b000;
                        C_J, C_JAL: bus.pc_sel = 3'b001;
                        C_JR, C_JALR: bus.pc_sel = 3'b010;
                        C_ERET:    bus.pc_sel = 3'b100;
                        C_TRAP:    bus.pc_sel = 3'b101;
                        default:   bus.pc_sel = 3'b000;
                    endcase
                    if (exc) begin
                        bus.pc_sel    = 3'b101;
                        bus.exc_pulse = 1'b1;
                        bus.rf_we     = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: the driver queues expected strobe events
// per instruction, the monitor pops and compares on every strobe cycle.
module tb_mc_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mc_seq_ctrl_if bus ();
    mc_seq_ctrl #(.MD_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    // strobes: {ir_we, pc_we, rf_we, dmem_we, md_start, exc_pulse, md_err}
    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic [6:0]  stb;
        logic [2:0]  pc;
        logic [2:0]  rd;
    } ev_t;

    typedef struct {
        logic [3:0] cls;
        logic       br;
        int         busy_n;
        logic       intr;
        int         len;
        logic       dm, ms, rf;
        logic [2:0] rd, pc;
        logic       exc, err;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[$];

    function automatic logic [6:0] strobes();
        return {bus.ir_we, bus.pc_we, bus.rf_we, bus.dmem_we,
                bus.md_start, bus.exc_pulse, bus.md_err};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [2:0] st, input logic [6:0] stb,
                           input logic [2:0] pc, input logic [2:0] rd);
        ev_t e;
        e.cyc = c; e.st = st; e.stb = stb; e.pc = pc; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input vec_t v);
        int t0 = cyc;
        push_ev(t0, 3'd0, 7'b1000000, 3'd0, 3'd0);
        if (v.ms) push_ev(t0 + 2, 3'd2, 7'b0000100, 3'd0, 3'd0);
        if (v.dm) push_ev(t0 + 3, 3'd3, 7'b0001000, 3'd0, 3'd0);
        push_ev(t0 + v.len - 1, 3'd5, {1'b0, 1'b1, v.rf, 1'b0, 1'b0, v.exc, v.err}, v.pc, v.rd);
        for (int i = 0; i < v.len; i++) begin
            bus.op_class = (i < 2) ? v.cls : ~v.cls;
            bus.br_taken = (i == 2) ? v.br : ~v.br;
            bus.md_busy  = (i >= 3 && i < 3 + v.busy_n);
            bus.int_req  = (i == v.len - 1) ? v.intr : 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // STORE aborted by reset during its MEM cycle: only the IF event may appear
    task automatic run_store_reset();
        int t0 = cyc;
        push_ev(t0, 3'd0, 7'b1000000, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            bus.op_class = (i < 2) ? 4'd2 : 4'd0;
            bus.br_taken = 1'b0;
            bus.md_busy  = 1'b0;
            bus.int_req  = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_outputs", {strobes(), bus.pc_sel, bus.rd_sel}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (strobes() != 7'd0) begin
                ev_t got, exp;
                got.cyc = cyc; got.st = bus.state; got.stb = strobes();
                got.pc = bus.pc_sel; got.rd = bus.rd_sel;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", got, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("event", got, exp);
                end
            end else begin
                check("idle_sel", {bus.pc_sel, bus.rd_sel}, 64'd0);
            end
        end
    end

    initial begin
        bus.op_class = 4'd0;
        bus.br_taken = 1'b0;
        bus.md_busy  = 1'b0;
        bus.int_req  = 1'b0;

        //              cls   br busy int len dm ms rf rd    pc    exc err
        vecs.push_back('{4'd0,  0, 0, 0, 4,  0, 0, 1, 3'd0, 3'd0, 0, 0}); // ALU
        vecs.push_back('{4'd1,  0, 0, 0, 5,  0, 0, 1, 3'd1, 3'd0, 0, 0}); // LOAD
        vecs.push_back('{4'd2,  0, 0, 0, 5,  1, 0, 0, 3'd0, 3'd0, 0, 0}); // STORE
        vecs.push_back('{4'd3,  1, 0, 0, 4,  0, 0, 0, 3'd0, 3'd3, 0, 0}); // BRANCH taken
        vecs.push_back('{4'd3,  0, 0, 0, 4,  0, 0, 0, 3'd0, 3'd0, 0, 0}); // BRANCH not taken
        vecs.push_back('{4'd6,  0, 0, 0, 4,  0, 0, 0, 3'd0, 3'd2, 0, 0}); // JR
        vecs.push_back('{4'd5,  0, 0, 0, 4,  0, 0, 1, 3'd2, 3'd1, 0, 0}); // JAL
        vecs.push_back('{4'd7,  0, 0, 0, 4,  0, 0, 1, 3'd2, 3'd2, 0, 0}); // JALR
        vecs.push_back('{4'd4,  0, 0, 0, 4,  0, 0, 0, 3'd0, 3'd1, 0, 0}); // J
        vecs.push_back('{4'd8,  0, 0, 0, 4,  0, 0, 1, 3'd3, 3'd0, 0, 0}); // MFC0
        vecs.push_back('{4'd10, 0, 0, 0, 4,  0, 0, 1, 3'd4, 3'd0, 0, 0}); // MFLO
        vecs.push_back('{4'd11, 0, 0, 0, 4,  0, 0, 1, 3'd5, 3'd0, 0, 0}); // MFHI
        vecs.push_back('{4'd12, 0, 0, 0, 4,  0, 0, 1, 3'd6, 3'd0, 0, 0}); // MUL
        vecs.push_back('{4'd13, 0, 0, 0, 4,  0, 0, 1, 3'd7, 3'd0, 0, 0}); // CLZ
        vecs.push_back('{4'd14, 0, 7, 0, 12, 0, 1, 0, 3'd0, 3'd0, 0, 0}); // MDOP, 8 waits
        vecs.push_back('{4'd14, 0, 0, 0, 5,  0, 1, 0, 3'd0, 3'd0, 0, 0}); // MDOP, 1 wait
        vecs.push_back('{4'd14, 0, 99, 0, 68, 0, 1, 0, 3'd0, 3'd0, 0, 1}); // MDOP timeout
        vecs.push_back('{4'd0,  0, 0, 1, 4,  0, 0, 0, 3'd0, 3'd5, 1, 0}); // ALU + interrupt
        vecs.push_back('{4'd9,  0, 0, 1, 4,  0, 0, 0, 3'd0, 3'd4, 0, 0}); // ERET + interrupt
        vecs.push_back('{4'd15, 0, 0, 0, 4,  0, 0, 0, 3'd0, 3'd5, 1, 0}); // TRAP
        vecs.push_back('{4'd15, 0, 0, 1, 4,  0, 0, 0, 3'd0, 3'd5, 1, 0}); // TRAP + interrupt
        vecs.push_back('{4'd1,  0, 0, 1, 5,  0, 0, 0, 3'd1, 3'd5, 1, 0}); // LOAD + interrupt

        @(posedge clk); #1;
        @(negedge clk);
        check("rst_outputs", {strobes(), bus.pc_sel, bus.rd_sel}, 64'd0);
        check("rst_state", bus.state, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state_2", bus.state, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[k]) run_instr(vecs[k]);
        run_store_reset();
        run_instr(vecs[0]);
        run_instr(vecs[2]);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
